// File: rtl/video_timing_gen.sv
// Native vsync/hsync/de raster generator with frame/line markers and active-pixel counters.
// Define VIDEO_TIMING_GEN_EXT_SYNC_EN to re-phase the raster to the external frame strobe ext_vs.
module video_timing_gen #(
  parameter int H_SYNC   = 44,
  parameter int H_BACK   = 148,
  parameter int H_FRONT  = 88,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 36,
  parameter int V_FRONT  = 4,
  parameter int SYNC_POL = 1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] hactive,
  input  logic [15:0] vactive,
  input  logic        ext_vs,
  output logic        vsync,
  output logic        hsync,
  output logic        de,
  output logic        sof,
  output logic        eol,
  output logic [15:0] hcnt,
  output logic [15:0] vcnt,
  output logic        locked
);

  localparam logic        SYNC_IDLE   = (SYNC_POL != 0) ? 1'b0 : 1'b1;
  localparam logic [16:0] H_SYNC_W    = 17'(H_SYNC);
  localparam logic [16:0] V_SYNC_W    = 17'(V_SYNC);
  localparam logic [16:0] H_ACT_START = 17'(H_SYNC + H_BACK);
  localparam logic [16:0] V_ACT_START = 17'(V_SYNC + V_BACK);
  localparam logic [16:0] H_BLANK     = 17'(H_SYNC + H_BACK + H_FRONT);
  localparam logic [16:0] V_BLANK     = 17'(V_SYNC + V_BACK + V_FRONT);

  logic [15:0] hpos, vpos, hpos_nxt, vpos_nxt;
  logic [15:0] hactive_l, vactive_l, hact_cur, vact_cur;
  logic [15:0] hcnt_d, vcnt_d;
  logic        at_origin, h_last, v_last;
  logic        hs, vs, hact, vact, de_d, sof_d, eol_d;
  logic        frame_restart;

  // At the frame origin the live inputs define this frame's geometry.
  always_comb begin
    at_origin = (hpos == 16'd0) && (vpos == 16'd0);
    hact_cur  = at_origin ? hactive : hactive_l;
    vact_cur  = at_origin ? vactive : vactive_l;
    h_last    = {1'b0, hpos} == (H_BLANK + {1'b0, hact_cur} - 17'd1);
    v_last    = {1'b0, vpos} == (V_BLANK + {1'b0, vact_cur} - 17'd1);
    hs        = {1'b0, hpos} < H_SYNC_W;
    vs        = {1'b0, vpos} < V_SYNC_W;
    hact      = ({1'b0, hpos} >= H_ACT_START) && ({1'b0, hpos} < (H_ACT_START + {1'b0, hact_cur}));
    vact      = ({1'b0, vpos} >= V_ACT_START) && ({1'b0, vpos} < (V_ACT_START + {1'b0, vact_cur}));
    de_d      = hact && vact;
    hcnt_d    = de_d ? (hpos - H_ACT_START[15:0]) : 16'd0;
    vcnt_d    = de_d ? (vpos - V_ACT_START[15:0]) : 16'd0;
    sof_d     = de_d && (hcnt_d == 16'd0) && (vcnt_d == 16'd0);
    eol_d     = de_d && ({1'b0, hcnt_d} == ({1'b0, hact_cur} - 17'd1));
    hpos_nxt  = hpos + 16'd1;
    vpos_nxt  = vpos;
    if (frame_restart) begin
      hpos_nxt = 16'd0;
      vpos_nxt = 16'd0;
    end else if (h_last) begin
      hpos_nxt = 16'd0;
      vpos_nxt = v_last ? 16'd0 : vpos + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst || !enable) begin
      hpos  <= 16'd0;
      vpos  <= 16'd0;
      hsync <= SYNC_IDLE;
      vsync <= SYNC_IDLE;
      de    <= 1'b0;
      sof   <= 1'b0;
      eol   <= 1'b0;
      hcnt  <= 16'd0;
      vcnt  <= 16'd0;
    end else begin
      hpos  <= hpos_nxt;
      vpos  <= vpos_nxt;
      hsync <= hs ^ SYNC_IDLE;
      vsync <= vs ^ SYNC_IDLE;
      de    <= de_d;
      sof   <= sof_d;
      eol   <= eol_d;
      hcnt  <= hcnt_d;
      vcnt  <= vcnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      hactive_l <= 16'd0;
      vactive_l <= 16'd0;
    end else if (at_origin) begin
      hactive_l <= hactive;
      vactive_l <= vactive;
    end
  end

`ifdef VIDEO_TIMING_GEN_EXT_SYNC_EN
  logic [2:0] ext_vs_sync;
  logic [1:0] align_cnt;

  assign frame_restart = enable && ext_vs_sync[1] && !ext_vs_sync[2];

  always_ff @(posedge clock) begin
    if (rst) ext_vs_sync <= 3'b000;
    else     ext_vs_sync <= {ext_vs_sync[1:0], ext_vs};
  end

  // An edge landing on the natural wrap counts toward lock; any other edge breaks it.
  always_ff @(posedge clock) begin
    if (rst || !enable) begin
      align_cnt <= 2'd0;
      locked    <= 1'b0;
    end else if (frame_restart) begin
      if (h_last && v_last) begin
        if (align_cnt != 2'd2) align_cnt <= align_cnt + 2'd1;
        locked <= (align_cnt != 2'd0);
      end else begin
        align_cnt <= 2'd0;
        locked    <= 1'b0;
      end
    end
  end
`else
  logic unused_ext_vs;
  assign unused_ext_vs = ext_vs;
  assign frame_restart = 1'b0;

  always_ff @(posedge clock) begin
    if (rst) locked <= 1'b0;
    else     locked <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a linear-position raster model predicts every cycle,
// a decoupled monitor compares, and directed scenarios check frame-level spacing.
module tb_video_timing_gen;

  localparam int  H_SYNC  = 2;
  localparam int  H_BACK  = 3;
  localparam int  H_FRONT = 1;
  localparam int  V_SYNC  = 1;
  localparam int  V_BACK  = 2;
  localparam int  V_FRONT = 1;
  localparam bit  POL_HIGH = 1'b1;
`ifdef VIDEO_TIMING_GEN_EXT_SYNC_EN
  localparam bit  EXT_SYNC = 1'b1;
`else
  localparam bit  EXT_SYNC = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst, enable, ext_vs;
  logic [15:0] hactive, vactive;
  logic        vsync, hsync, de, sof, eol, locked;
  logic [15:0] hcnt, vcnt;

  video_timing_gen #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_FRONT(H_FRONT),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_FRONT(V_FRONT), .SYNC_POL(1)
  ) dut (
    .clock(clock), .rst(rst), .enable(enable), .hactive(hactive), .vactive(vactive),
    .ext_vs(ext_vs), .vsync(vsync), .hsync(hsync), .de(de), .sof(sof), .eol(eol),
    .hcnt(hcnt), .vcnt(vcnt), .locked(locked)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic vsync, hsync, de, sof, eol, locked;
    logic [15:0] hcnt, vcnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_cnt = 0;
  int   last_drive_edge = 0;
  int   sof_log[$];
  int   hs_rise[$];
  int   vs_rise[$];
  logic prev_hs = 1'b0;
  logic prev_vs = 1'b0;

  // Reference model: one linear position within the frame; geometry fixed at position 0.
  int m_pos = 0;
  int m_fh = 0;
  int m_fv = 0;
  int m_lock_cnt = 0;
  bit ext_past[3] = '{1'b0, 1'b0, 1'b0};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit en, input int ha, input int va, input bit ev);
    exp_t e;
    bit   ext_edge;
    int   ht, vt, x, y;
    @(negedge clock);
    last_drive_edge = edge_cnt;
    rst = r; enable = en; hactive = 16'(ha); vactive = 16'(va); ext_vs = ev;
    e.vsync = !POL_HIGH; e.hsync = !POL_HIGH;
    e.de = 1'b0; e.sof = 1'b0; e.eol = 1'b0; e.hcnt = 16'd0; e.vcnt = 16'd0;
    e.locked = 1'b0;
    ext_edge = EXT_SYNC && ext_past[1] && !ext_past[2];
    if (r || !en) begin
      m_pos = 0;
      m_lock_cnt = 0;
      e.locked = (r || EXT_SYNC) ? 1'b0 : 1'b1;
    end else begin
      if (m_pos == 0) begin m_fh = ha; m_fv = va; end
      ht = H_SYNC + H_BACK + m_fh + H_FRONT;
      vt = V_SYNC + V_BACK + m_fv + V_FRONT;
      x = m_pos % ht;
      y = m_pos / ht;
      e.hsync = ((x < H_SYNC) == POL_HIGH);
      e.vsync = ((y < V_SYNC) == POL_HIGH);
      e.de = (x >= H_SYNC + H_BACK) && (x < H_SYNC + H_BACK + m_fh) &&
             (y >= V_SYNC + V_BACK) && (y < V_SYNC + V_BACK + m_fv);
      if (e.de) begin
        e.hcnt = 16'(x - H_SYNC - H_BACK);
        e.vcnt = 16'(y - V_SYNC - V_BACK);
      end
      e.sof = e.de && (x == H_SYNC + H_BACK) && (y == V_SYNC + V_BACK);
      e.eol = e.de && (x == H_SYNC + H_BACK + m_fh - 1);
      if (ext_edge) begin
        if (m_pos == ht * vt - 1) m_lock_cnt = (m_lock_cnt < 2) ? m_lock_cnt + 1 : 2;
        else m_lock_cnt = 0;
        m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % (ht * vt);
      end
      e.locked = EXT_SYNC ? (m_lock_cnt >= 2) : 1'b1;
    end
    if (r) ext_past = '{1'b0, 1'b0, 1'b0};
    else begin
      ext_past[2] = ext_past[1];
      ext_past[1] = ext_past[0];
      ext_past[0] = ev;
    end
    exp_q.push_back(e);
  endtask

  always @(posedge clock) begin
    #1;
    edge_cnt++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checkOutput($sformatf("raster@%0d", edge_cnt),
                  {26'd0, vsync, hsync, de, sof, eol, locked, hcnt, vcnt},
                  {26'd0, mon_e.vsync, mon_e.hsync, mon_e.de, mon_e.sof, mon_e.eol,
                   mon_e.locked, mon_e.hcnt, mon_e.vcnt});
    end
    if (sof === 1'b1) sof_log.push_back(edge_cnt);
    if (hsync === 1'b1 && prev_hs === 1'b0) hs_rise.push_back(edge_cnt);
    if (vsync === 1'b1 && prev_vs === 1'b0) vs_rise.push_back(edge_cnt);
    prev_hs = hsync;
    prev_vs = vsync;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  int en_edge, steps, frame, ha_r, va_r, len;
  bit r_r, en_r, ev_r;

  initial begin
    rst = 1'b1; enable = 1'b0; hactive = 16'd8; vactive = 16'd4; ext_vs = 1'b0;
    repeat (3) applyStimulus(1, 0, 8, 4, 0);
    applyStimulus(0, 0, 8, 4, 0);

    $display("[TB] scenario 1/2: 8x4 raster, two frames");
    sof_log.delete();
    applyStimulus(0, 1, 8, 4, 0);
    en_edge = last_drive_edge;
    repeat (239) applyStimulus(0, 1, 8, 4, 0);
    checkOutput("sof_count_8x4", 64'(sof_log.size() >= 2), 64'd1);
    if (sof_log.size() >= 2) begin
      checkOutput("first_sof_offset", 64'(sof_log[0] - en_edge), 64'(1 + 14 * 3 + 5));
      checkOutput("sof_period_8x4", 64'(sof_log[1] - sof_log[0]), 64'd112);
    end

    $display("[TB] scenario 3: hactive 8->4 mid-frame");
    steps = 0;
    while (m_pos != 60 && steps < 200) begin applyStimulus(0, 1, 8, 4, 0); steps++; end
    sof_log.delete();
    repeat (262) applyStimulus(0, 1, 4, 4, 0);
    checkOutput("sof_count_4x4", 64'(sof_log.size() >= 2), 64'd1);
    if (sof_log.size() >= 2)
      checkOutput("sof_period_4x4", 64'(sof_log[1] - sof_log[0]), 64'd80);

    $display("[TB] scenario 4: hactive=0 blanking-only raster");
    steps = 0;
    while (!(m_fh == 0 && m_pos == 1) && steps < 200) begin applyStimulus(0, 1, 0, 4, 0); steps++; end
    sof_log.delete(); hs_rise.delete(); vs_rise.delete();
    repeat (3 * 48 + 6) applyStimulus(0, 1, 0, 4, 0);
    checkOutput("no_sof_blank", 64'(sof_log.size()), 64'd0);
    checkOutput("hsync_rises", 64'(hs_rise.size() >= 2), 64'd1);
    if (hs_rise.size() >= 2)
      checkOutput("hsync_period", 64'(hs_rise[hs_rise.size()-1] - hs_rise[hs_rise.size()-2]), 64'd6);
    checkOutput("vsync_rises", 64'(vs_rise.size() >= 2), 64'd1);
    if (vs_rise.size() >= 2)
      checkOutput("vsync_period", 64'(vs_rise[vs_rise.size()-1] - vs_rise[vs_rise.size()-2]), 64'd48);

    $display("[TB] scenario 5: reset during active line");
    steps = 0;
    while (!(m_fh == 8 && m_pos == 3 * 14 + 9) && steps < 400) begin applyStimulus(0, 1, 8, 4, 0); steps++; end
    applyStimulus(1, 1, 8, 4, 0);
    applyStimulus(0, 0, 8, 4, 0);
    sof_log.delete();
    applyStimulus(0, 1, 8, 4, 0);
    en_edge = last_drive_edge;
    repeat (119) applyStimulus(0, 1, 8, 4, 0);
    checkOutput("sof_after_reset", 64'(sof_log.size() >= 1), 64'd1);
    if (sof_log.size() >= 1)
      checkOutput("sof_offset_after_reset", 64'(sof_log[0] - en_edge), 64'd48);

`ifdef VIDEO_TIMING_GEN_EXT_SYNC_EN
    $display("[TB] scenario 6: external frame strobe lock");
    repeat (3) applyStimulus(0, 0, 8, 4, 0);
    frame = -1;
    for (int c = 0; c < 112 * 6 + 60; c++) begin
      if (m_pos == 0) frame++;
      if (frame == 2 && m_pos == 50) checkOutput("locked_acquire", 64'(locked), 64'd1);
      if (frame == 4 && m_pos == 50) checkOutput("locked_drop", 64'(locked), 64'd0);
      if (frame == 6 && m_pos == 50) checkOutput("locked_reacquire", 64'(locked), 64'd1);
      ev_r = (frame == 3) ? (m_pos >= 99 && m_pos <= 101) : (m_pos >= 109);
      applyStimulus(0, 1, 8, 4, ev_r);
    end
`endif

    $display("[TB] randomized phase");
    ev_r = 1'b0;
    for (int seg = 0; seg < 8; seg++) begin
      ha_r = int'($urandom_range(0, 6));
      va_r = int'($urandom_range(0, 4));
      len  = int'($urandom_range(60, 250));
      for (int c = 0; c < len; c++) begin
        r_r  = ($urandom_range(0, 99) == 0);
        en_r = ($urandom_range(0, 99) > 1);
        if ($urandom_range(0, 19) == 0) ha_r = int'($urandom_range(0, 6));
        if ($urandom_range(0, 19) == 0) va_r = int'($urandom_range(0, 4));
        if ($urandom_range(0, 29) == 0) ev_r = !ev_r;
        applyStimulus(r_r, en_r, ha_r, va_r, ev_r);
      end
    end

    applyStimulus(1, 0, 8, 4, 0);
    applyStimulus(1, 0, 8, 4, 0);
    @(posedge clock);
    #2;
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
